// File: rtl/elevator_controller_n_if.sv
// Elevator controller signal bundle.
// Groups the button/sensor inputs and the status outputs of the car controller
// into one interface.
//   master : front end / display side (drives call_req, sos, overweight)
//   slave  : elevator_controller_n (drives pending, floor and door/motion status)
// Ports carried:
//   call_req[FLOORS]      per-floor call buttons (level)
//   sos, overweight       emergency stop and load sensor (level)
//   pending[FLOORS]       latched requests (LED drive)
//   floor_onehot[FLOORS]  current floor, one-hot
//   current_floor         current floor, binary
//   door_open, moving, dir_up, sos_mode, weight_limit_exceeded  status flags
interface elevator_controller_n_if #(
  parameter int FLOORS  = 3,
  parameter int FLOOR_W = 2
);
  logic [FLOORS-1:0]  call_req;
  logic               sos;
  logic               overweight;
  logic [FLOORS-1:0]  pending;
  logic [FLOORS-1:0]  floor_onehot;
  logic [FLOOR_W-1:0] current_floor;
  logic               door_open;
  logic               moving;
  logic               dir_up;
  logic               sos_mode;
  logic               weight_limit_exceeded;

  modport master (
    output call_req, sos, overweight,
    input  pending, floor_onehot, current_floor, door_open, moving,
           dir_up, sos_mode, weight_limit_exceeded
  );

  modport slave (
    input  call_req, sos, overweight,
    output pending, floor_onehot, current_floor, door_open, moving,
           dir_up, sos_mode, weight_limit_exceeded
  );
endinterface

// File: rtl/elevator_controller_n.sv
// N-floor elevator car controller.
// Latches per-floor calls and serves them in SCAN order, sequencing
// cycle-counted travel and door phases. Overweight holds the door open, SOS
// parks the car with the door shut until released.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : elevator_controller_n_if.slave (calls, sos, overweight in;
//          pending, floor, door and motion status out, all registered)
module elevator_controller_n #(
  parameter int FLOORS      = 3,
  parameter int FLOOR_W     = 2,
  parameter int MOVE_CYCLES = 5,
  parameter int DOOR_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  elevator_controller_n_if.slave bus
);

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP       = FLOOR_W'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR, SOS} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [FLOORS-1:0]  pending;
  logic [FLOORS-1:0]  floor_onehot;
  logic [FLOOR_W-1:0] cur;
  logic               dir_up;
  logic               door_open;
  logic               moving;
  logic               sos_mode;
  logic               wle;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < FLOORS; i++)
      if (FLOOR_W'(i) == f) m[i] = 1'b1;
    return m;
  endfunction

  // Floors strictly past f in the given direction.
  function automatic logic [FLOORS-1:0] beyond(input logic [FLOOR_W-1:0] f,
                                               input logic up);
    logic [FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < FLOORS; i++)
      if (up ? (FLOOR_W'(i) > f) : (FLOOR_W'(i) < f)) m[i] = 1'b1;
    return m;
  endfunction

  logic [FLOORS-1:0]  here;
  logic [FLOORS-1:0]  latched;
  logic [FLOORS-1:0]  latched_away;
  logic [FLOORS-1:0]  nf_hot;
  logic [FLOOR_W-1:0] nf;
  logic               here_call;
  logic               next_dir;
  logic               nf_dir;

  always_comb begin
    here         = onehot(cur);
    latched      = pending | bus.call_req;
    // A call for the floor the car stands at (door or idle) opens the door
    // instead of lighting its LED; existing bits are never dropped here.
    latched_away = pending | (bus.call_req & ~here);
    here_call    = |(bus.call_req & here);
    next_dir     = (|(pending & beyond(cur, dir_up))) ? dir_up : ~dir_up;
    if (cur == '0)       next_dir = 1'b1;
    else if (cur == TOP) next_dir = 1'b0;
    nf     = dir_up ? cur + FLOOR_W'(1) : cur - FLOOR_W'(1);
    nf_hot = onehot(nf);
    nf_dir = dir_up;
    if (nf == '0)       nf_dir = 1'b1;
    else if (nf == TOP) nf_dir = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      cur          <= '0;
      floor_onehot <= FLOORS'(1);
      dir_up       <= 1'b1;
      door_open    <= 1'b0;
      moving       <= 1'b0;
      sos_mode     <= 1'b0;
      wle          <= 1'b0;
    end else if (bus.sos) begin
      // Park immediately; a travel step due on this edge is abandoned so the
      // floor stays at its last whole-floor value.
      state     <= SOS;
      cnt       <= '0;
      pending   <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      sos_mode  <= 1'b1;
      wle       <= 1'b0;
    end else begin
      case (state)
        SOS: begin
          state     <= DOOR;
          cnt       <= DOOR_LOAD;
          door_open <= 1'b1;
          sos_mode  <= 1'b0;
        end
        IDLE: begin
          pending <= latched_away;
          if (pending != '0) begin
            dir_up <= next_dir;
            state  <= MOVING;
            cnt    <= MOVE_LOAD;
            moving <= 1'b1;
          end else if (here_call) begin
            state     <= DOOR;
            cnt       <= DOOR_LOAD;
            door_open <= 1'b1;
          end
        end
        MOVING: begin
          if (cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
            pending <= latched;
          end else begin
            cur          <= nf;
            floor_onehot <= nf_hot;
            dir_up       <= nf_dir;
            if (|(latched & nf_hot)) begin
              pending   <= latched & ~nf_hot;
              state     <= DOOR;
              cnt       <= DOOR_LOAD;
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (|(latched & beyond(nf, dir_up))) begin
              pending <= latched;
              cnt     <= MOVE_LOAD;
            end else begin
              pending <= latched;
              state   <= IDLE;
              moving  <= 1'b0;
            end
          end
        end
        DOOR: begin
          pending <= latched_away;
          if (bus.overweight) begin
            wle <= 1'b1;
            cnt <= DOOR_LOAD;
          end else begin
            wle <= 1'b0;
            if (here_call)       cnt <= DOOR_LOAD;
            else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
            else begin
              state     <= IDLE;
              door_open <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pending               = pending;
  assign bus.floor_onehot          = floor_onehot;
  assign bus.current_floor         = cur;
  assign bus.door_open             = door_open;
  assign bus.moving                = moving;
  assign bus.dir_up                = dir_up;
  assign bus.sos_mode              = sos_mode;
  assign bus.weight_limit_exceeded = wle;

endmodule

// File: tb/tb_elevator_controller_n.sv
// Directed bench for elevator_controller_n (FLOORS=4, MOVE_CYCLES=5,
// DOOR_CYCLES=2). Expected snapshots are queued when each stimulus is driven
// and popped as the car reaches each observation point.
module tb_elevator_controller_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elevator_controller_n_if #(.FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_controller_n #(
    .FLOORS(4), .FLOOR_W(2), .MOVE_CYCLES(5), .DOOR_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  // Snapshot layout: {onehot[3:0], pending[3:0], floor[1:0], door, moving, dir_up, sos_mode, wle}
  function automatic logic [31:0] mk(logic [3:0] p, int c, logic d, logic m,
                                     logic u, logic s, logic w);
    logic [3:0] oh;
    logic [1:0] cf;
    oh = 4'b0001 << c;
    cf = 2'(c);
    return {17'b0, oh, p, cf, d, m, u, s, w};
  endfunction

  function automatic logic [31:0] snap();
    return {17'b0, bus.floor_onehot, bus.pending, bus.current_floor, bus.door_open,
            bus.moving, bus.dir_up, bus.sos_mode, bus.weight_limit_exceeded};
  endfunction

  task automatic E(string t, logic [3:0] p, int c, logic d, logic m,
                   logic u, logic s, logic w);
    exp_t e;
    e.tag = t;
    e.val = mk(p, c, d, m, u, s, w);
    sb.push_back(e);
  endtask

  task automatic EV(string t, logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_fails++;
      $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      n_asserts++;
      assert (obs === e.val)
      else begin
        n_fails++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs[14:0], e.val[14:0]);
      end
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int cycles;
  int viol;

  initial begin
    bus.call_req   = '0;
    bus.sos        = 1'b0;
    bus.overweight = 1'b0;

    // Reset state
    tick(3);
    rst = 1'b0;
    E("reset", 4'h0, 0, 0, 0, 1, 0, 0);
    check(snap());

    // Trip 0 -> 3
    bus.call_req = 4'b1000;
    E("A_latch",  4'h8, 0, 0, 0, 1, 0, 0);
    E("A_depart", 4'h8, 0, 0, 1, 1, 0, 0);
    E("A_pre1",   4'h8, 0, 0, 1, 1, 0, 0);
    E("A_f1",     4'h8, 1, 0, 1, 1, 0, 0);
    E("A_f2",     4'h8, 2, 0, 1, 1, 0, 0);
    E("A_arr3",   4'h0, 3, 1, 0, 0, 0, 0);
    E("A_door",   4'h0, 3, 1, 0, 0, 0, 0);
    E("A_close",  4'h0, 3, 0, 0, 0, 0, 0);
    tick(); bus.call_req = '0; check(snap());
    tick();  check(snap());
    tick(4); check(snap());
    tick();  check(snap());
    tick(5); check(snap());
    tick(5); check(snap());
    tick();  check(snap());
    tick();  check(snap());

    // Trip 3 -> 0, direction down, forced up again at floor 0
    bus.call_req = 4'b0001;
    E("D_latch",  4'h1, 3, 0, 0, 0, 0, 0);
    E("D_depart", 4'h1, 3, 0, 1, 0, 0, 0);
    E("D_f2",     4'h1, 2, 0, 1, 0, 0, 0);
    E("D_f1",     4'h1, 1, 0, 1, 0, 0, 0);
    E("D_arr0",   4'h0, 0, 1, 0, 1, 0, 0);
    E("D_door",   4'h0, 0, 1, 0, 1, 0, 0);
    E("D_close",  4'h0, 0, 0, 0, 1, 0, 0);
    tick(); bus.call_req = '0; check(snap());
    tick();  check(snap());
    tick(5); check(snap());
    tick(5); check(snap());
    tick(5); check(snap());
    tick();  check(snap());
    tick();  check(snap());

    // SOS three cycles into travel 0 -> 2
    bus.call_req = 4'b0100;
    E("S_latch",   4'h4, 0, 0, 0, 1, 0, 0);
    E("S_depart",  4'h4, 0, 0, 1, 1, 0, 0);
    E("S_enter",   4'h0, 0, 0, 0, 1, 1, 0);
    E("S_ignore",  4'h0, 0, 0, 0, 1, 1, 0);
    E("S_exit",    4'h0, 0, 1, 0, 1, 0, 0);
    E("S_door",    4'h0, 0, 1, 0, 1, 0, 0);
    E("S_close",   4'h0, 0, 0, 0, 1, 0, 0);
    tick(); bus.call_req = '0; check(snap());
    tick();  check(snap());
    tick(2); bus.sos = 1'b1;
    tick();  check(snap());
    bus.call_req = 4'b0010;
    tick();  check(snap());
    bus.call_req = '0; bus.sos = 1'b0;
    tick();  check(snap());
    tick();  check(snap());
    tick();  check(snap());

    // SCAN: heading up to 3, call for 0 latched at floor 1
    bus.call_req = 4'b1000;
    E("B_latch",  4'h8, 0, 0, 0, 1, 0, 0);
    E("B_depart", 4'h8, 0, 0, 1, 1, 0, 0);
    E("B_f1",     4'h8, 1, 0, 1, 1, 0, 0);
    E("B_call0",  4'h9, 1, 0, 1, 1, 0, 0);
    E("B_f2",     4'h9, 2, 0, 1, 1, 0, 0);
    E("B_arr3",   4'h1, 3, 1, 0, 0, 0, 0);
    E("B_door",   4'h1, 3, 1, 0, 0, 0, 0);
    E("B_idle",   4'h1, 3, 0, 0, 0, 0, 0);
    E("B_rev",    4'h1, 3, 0, 1, 0, 0, 0);
    EV("B_down_cycles", 32'd15);
    EV("B_dir_up_while_down", 32'd0);
    E("B_arr0",   4'h0, 0, 1, 0, 1, 0, 0);
    E("B_close",  4'h0, 0, 0, 0, 1, 0, 0);
    tick(); bus.call_req = '0; check(snap());
    tick();  check(snap());
    tick(5); check(snap());
    bus.call_req = 4'b0001;
    tick(); bus.call_req = '0; check(snap());
    tick(4); check(snap());
    tick(5); check(snap());
    tick();  check(snap());
    tick();  check(snap());
    tick();  check(snap());
    cycles = 0;
    viol   = 0;
    while (!(bus.door_open && bus.current_floor == 2'd0) && cycles < 40) begin
      tick();
      cycles++;
      if (bus.moving && bus.dir_up) viol++;
    end
    check(32'(cycles));
    check(32'(viol));
    check(snap());
    tick(2); check(snap());

    // Overweight held 7 cycles at floor 2
    bus.call_req = 4'b0100;
    E("W_latch",  4'h4, 0, 0, 0, 1, 0, 0);
    E("W_depart", 4'h4, 0, 0, 1, 1, 0, 0);
    E("W_arr2",   4'h0, 2, 1, 0, 1, 0, 0);
    E("W_ow1",    4'h0, 2, 1, 0, 1, 0, 1);
    E("W_ow7",    4'h0, 2, 1, 0, 1, 0, 1);
    E("W_tail",   4'h0, 2, 1, 0, 1, 0, 0);
    E("W_close",  4'h0, 2, 0, 0, 1, 0, 0);
    tick(); bus.call_req = '0; check(snap());
    tick();   check(snap());
    tick(10); check(snap());
    bus.overweight = 1'b1;
    tick();   check(snap());
    tick(6);  check(snap());
    bus.overweight = 1'b0;
    tick();   check(snap());
    tick();   check(snap());

    // Call for the floor the car is at: door opens, re-calls hold it
    bus.call_req = 4'b0100;
    E("H_open",   4'h0, 2, 1, 0, 1, 0, 0);
    E("H_hold1",  4'h0, 2, 1, 0, 1, 0, 0);
    E("H_hold2",  4'h0, 2, 1, 0, 1, 0, 0);
    E("H_tail",   4'h0, 2, 1, 0, 1, 0, 0);
    E("H_close",  4'h0, 2, 0, 0, 1, 0, 0);
    tick(); check(snap());
    tick(); check(snap());
    tick(); check(snap());
    bus.call_req = '0;
    tick(); check(snap());
    tick(); check(snap());

    // Asynchronous reset mid-travel 2 -> 0
    bus.call_req = 4'b0001;
    E("R_latch",  4'h1, 2, 0, 0, 1, 0, 0);
    E("R_depart", 4'h1, 2, 0, 1, 0, 0, 0);
    E("R_f1",     4'h1, 1, 0, 1, 0, 0, 0);
    E("R_mid",    4'h1, 1, 0, 1, 0, 0, 0);
    E("R_async",  4'h0, 0, 0, 0, 1, 0, 0);
    E("R_after",  4'h0, 0, 0, 0, 1, 0, 0);
    tick(); bus.call_req = '0; check(snap());
    tick();  check(snap());
    tick(5); check(snap());
    tick(2); check(snap());
    #2 rst = 1'b1;
    #1 check(snap());
    tick(); rst = 1'b0;
    tick(); check(snap());

    n_asserts++;
    assert (sb.size() == 0)
    else begin
      n_fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
